// File: rtl/hwacc_mr_mtt_req_gen_if.sv
// Bus bundle between the MR translation request generator and its environment:
// request input, PageOffsetBuffer write port, MTT get channel and error channel.

`ifndef MAX_REQ_TAG_NUM_LOG
`define MAX_REQ_TAG_NUM_LOG 8
`endif

interface hwacc_mr_mtt_req_gen_if #(
    parameter int unsigned ICM_ADDR_WIDTH      = 64,
    parameter int unsigned PHYSICAL_ADDR_WIDTH = 64,
    parameter int unsigned COUNT_MAX_LOG       = 2,
    parameter int unsigned TAG_WIDTH           = `MAX_REQ_TAG_NUM_LOG
);
    localparam int unsigned HeadWidth =
        COUNT_MAX_LOG * 2 + TAG_WIDTH + PHYSICAL_ADDR_WIDTH + ICM_ADDR_WIDTH;

    logic                      mr_req_valid;
    logic [TAG_WIDTH-1:0]      mr_req_tag;
    logic [63:0]               mr_req_vaddr;
    logic [31:0]               mr_req_len;
    logic [63:0]               mr_req_start_va;
    logic [ICM_ADDR_WIDTH-1:0] mr_req_mtt_base;
    logic                      mr_req_ready;

    logic                      page_offset_buffer_wen;
    logic [TAG_WIDTH-1:0]      page_offset_buffer_addr;
    logic [43:0]               page_offset_buffer_din;

    logic                      mtt_get_req_valid;
    logic [HeadWidth-1:0]      mtt_get_req_head;
    logic                      mtt_get_req_ready;

    logic                      mr_err_valid;
    logic [TAG_WIDTH-1:0]      mr_err_tag;

    // Request generator side: it masters the buffer write and the MTT get channel.
    modport master (
        input  mr_req_valid, mr_req_tag, mr_req_vaddr, mr_req_len, mr_req_start_va,
               mr_req_mtt_base, mtt_get_req_ready,
        output mr_req_ready, page_offset_buffer_wen, page_offset_buffer_addr,
               page_offset_buffer_din, mtt_get_req_valid, mtt_get_req_head,
               mr_err_valid, mr_err_tag
    );

    // Environment side: request source, buffer, MTTCache and error sink.
    modport slave (
        output mr_req_valid, mr_req_tag, mr_req_vaddr, mr_req_len, mr_req_start_va,
               mr_req_mtt_base, mtt_get_req_ready,
        input  mr_req_ready, page_offset_buffer_wen, page_offset_buffer_addr,
               page_offset_buffer_din, mtt_get_req_valid, mtt_get_req_head,
               mr_err_valid, mr_err_tag
    );
endinterface

// File: rtl/hwacc_mr_mtt_req_gen.sv
// MR translation request generator: takes one request, computes page offset and
// page count, writes {len, offset} to the PageOffsetBuffer at the tag, then issues
// one MTT get per page. Requests spanning too many pages or below the MR start
// are reported on the error channel instead.

`ifndef MAX_REQ_TAG_NUM_LOG
`define MAX_REQ_TAG_NUM_LOG 8
`endif

module hwacc_mr_mtt_req_gen #(
    parameter int unsigned ICM_ADDR_WIDTH      = 64,
    parameter int unsigned PHYSICAL_ADDR_WIDTH = 64,
    parameter int unsigned COUNT_MAX           = 2,
    parameter int unsigned COUNT_MAX_LOG       = 2,
    parameter int unsigned MTT_ENTRY_SIZE_LOG  = 3,
    parameter int unsigned PAGE_SIZE_LOG       = 12,
    parameter int unsigned TAG_WIDTH           = `MAX_REQ_TAG_NUM_LOG
) (
    input  logic                     clk,
    input  logic                     rst,
    hwacc_mr_mtt_req_gen_if.master   bus
);

    localparam int unsigned PageIdxWidth = 64 - PAGE_SIZE_LOG;

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StWrBuf,
        StReq0,
        StReq1,
        StErr
    } state_e;

    state_e state_q, state_d;

    logic [TAG_WIDTH-1:0]      tag_q;
    logic [63:0]               vaddr_q;
    logic [31:0]               len_q;
    logic [63:0]               start_va_q;
    logic [ICM_ADDR_WIDTH-1:0] base_q;
    logic [COUNT_MAX_LOG-1:0]  count_q;
    logic [ICM_ADDR_WIDTH-1:0] icm0_q;
    logic [ICM_ADDR_WIDTH-1:0] icm1_q;

    logic [PAGE_SIZE_LOG-1:0]  offset;
    logic [32:0]               span;
    logic [PageIdxWidth-1:0]   page_idx;
    logic [ICM_ADDR_WIDTH-1:0] icm0;
    logic [ICM_ADDR_WIDTH-1:0] icm1;
    logic                      multi_page;
    logic                      req_bad;
    logic                      req_fire;
    logic                      get_fire;

    assign req_fire = bus.mr_req_valid && bus.mr_req_ready;
    assign get_fire = bus.mtt_get_req_valid && bus.mtt_get_req_ready;

    // Address arithmetic on the registered request; consumed in StCheck.
    always_comb begin
        offset     = vaddr_q[PAGE_SIZE_LOG-1:0];
        span       = {1'b0, len_q} + 33'(offset);
        page_idx   = vaddr_q[63:PAGE_SIZE_LOG] - start_va_q[63:PAGE_SIZE_LOG];
        icm0       = base_q + (ICM_ADDR_WIDTH'(page_idx) << MTT_ENTRY_SIZE_LOG);
        icm1       = icm0 + (ICM_ADDR_WIDTH'(1) << MTT_ENTRY_SIZE_LOG);
        multi_page = span > (33'd1 << PAGE_SIZE_LOG);
        req_bad    = (span > (33'(COUNT_MAX) << PAGE_SIZE_LOG)) || (vaddr_q < start_va_q);
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Request capture in StIdle, derived page count and MTT addresses in StCheck.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q      <= '0;
            vaddr_q    <= '0;
            len_q      <= '0;
            start_va_q <= '0;
            base_q     <= '0;
            count_q    <= '0;
            icm0_q     <= '0;
            icm1_q     <= '0;
        end else if (state_q == StIdle && req_fire) begin
            tag_q      <= bus.mr_req_tag;
            vaddr_q    <= bus.mr_req_vaddr;
            len_q      <= bus.mr_req_len;
            start_va_q <= bus.mr_req_start_va;
            base_q     <= bus.mr_req_mtt_base;
        end else if (state_q == StCheck) begin
            count_q    <= multi_page ? COUNT_MAX_LOG'(COUNT_MAX) : COUNT_MAX_LOG'(1);
            icm0_q     <= icm0;
            icm1_q     <= icm1;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (req_fire) state_d = StCheck;
            StCheck: state_d = req_bad ? StErr : StWrBuf;
            StWrBuf: state_d = StReq0;
            StReq0: begin
                if (get_fire) begin
                    state_d = (count_q == COUNT_MAX_LOG'(COUNT_MAX)) ? StReq1 : StIdle;
                end
            end
            StReq1:  if (get_fire) state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from the current state; ready is forced low during reset.
    always_comb begin
        bus.mr_req_ready            = (state_q == StIdle) && !rst;
        bus.page_offset_buffer_wen  = 1'b0;
        bus.page_offset_buffer_addr = tag_q;
        bus.page_offset_buffer_din  = '0;
        bus.mtt_get_req_valid       = 1'b0;
        bus.mtt_get_req_head        = '0;
        bus.mr_err_valid            = 1'b0;
        bus.mr_err_tag              = '0;
        unique case (state_q)
            StWrBuf: begin
                bus.page_offset_buffer_wen = 1'b1;
                bus.page_offset_buffer_din = {len_q, offset};
            end
            StReq0: begin
                bus.mtt_get_req_valid = 1'b1;
                bus.mtt_get_req_head  = {count_q, COUNT_MAX_LOG'(1), tag_q,
                                         {PHYSICAL_ADDR_WIDTH{1'b0}}, icm0_q};
            end
            StReq1: begin
                bus.mtt_get_req_valid = 1'b1;
                bus.mtt_get_req_head  = {COUNT_MAX_LOG'(COUNT_MAX), COUNT_MAX_LOG'(2), tag_q,
                                         {PHYSICAL_ADDR_WIDTH{1'b0}}, icm1_q};
            end
            StErr: begin
                bus.mr_err_valid = 1'b1;
                bus.mr_err_tag   = tag_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_hwacc_mr_mtt_req_gen.sv
// Scoreboard bench for hwacc_mr_mtt_req_gen: stimulus pushes hand-computed
// expectations, a negedge monitor pops and compares on every DUT output event.

module tb_hwacc_mr_mtt_req_gen;

    localparam int HW = 140;

    logic clk;
    logic rst;

    hwacc_mr_mtt_req_gen_if bus ();

    hwacc_mr_mtt_req_gen dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [7:0]  tag;
        logic [63:0] vaddr;
        logic [63:0] sva;
        logic [31:0] len;
        logic [63:0] base;
        bit          err;
        logic [1:0]  cnt;
        logic [11:0] off;
        logic [63:0] icm0;
        logic [63:0] icm1;
        int          lat;
    } vec_t;

    vec_t vec [10];

    logic [7:0]    exp_err [$];
    logic [51:0]   exp_buf [$];
    logic [HW-1:0] exp_get [$];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [HW-1:0] mk_head(input logic [1:0] cnt, input logic [1:0] idx,
                                              input logic [7:0] tag, input logic [63:0] icm);
        return {cnt, idx, tag, 64'd0, icm};
    endfunction

    task automatic push_exp(input vec_t v);
        if (v.err) begin
            exp_err.push_back(v.tag);
        end else begin
            exp_buf.push_back({v.tag, v.len, v.off});
            exp_get.push_back(mk_head(v.cnt, 2'd1, v.tag, v.icm0));
            if (v.cnt == 2'd2) exp_get.push_back(mk_head(2'd2, 2'd2, v.tag, v.icm1));
        end
    endtask

    task automatic wait_idle(input string nm, output int n);
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            n++;
            if (bus.mr_req_ready) break;
        end
        if (!bus.mr_req_ready) chk({nm, "_idle_timeout"}, 0, 1);
    endtask

    task automatic send(input vec_t v, input bit wait_done);
        int n;
        @(posedge clk);
        #1;
        chk("req_ready_in_idle", bus.mr_req_ready, 1);
        push_exp(v);
        bus.mr_req_valid    = 1'b1;
        bus.mr_req_tag      = v.tag;
        bus.mr_req_vaddr    = v.vaddr;
        bus.mr_req_len      = v.len;
        bus.mr_req_start_va = v.sva;
        bus.mr_req_mtt_base = v.base;
        @(posedge clk);
        #1;
        bus.mr_req_valid = 1'b0;
        if (wait_done) begin
            wait_idle("send", n);
            if (v.lat != 0) chk("accept_to_ready_cycles", n, v.lat);
        end
    endtask

    task automatic wait_get_valid(input string nm);
        for (int i = 0; i < 20; i++) begin
            if (bus.mtt_get_req_valid) break;
            @(posedge clk);
            #1;
        end
        if (!bus.mtt_get_req_valid) chk({nm, "_valid_timeout"}, 0, 1);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_ready"}, bus.mr_req_ready, 0);
        chk({nm, "_wen"}, bus.page_offset_buffer_wen, 0);
        chk({nm, "_din"}, bus.page_offset_buffer_din, 0);
        chk({nm, "_get_valid"}, bus.mtt_get_req_valid, 0);
        chk({nm, "_get_head"}, bus.mtt_get_req_head, 0);
        chk({nm, "_err_valid"}, bus.mr_err_valid, 0);
    endtask

    // Monitor: compares every buffer write, MTT handshake and error pulse.
    logic          stall_q;
    logic [HW-1:0] prev_head;
    logic          wrote;
    logic [7:0]    wrote_tag;

    always @(negedge clk) begin
        if (rst) begin
            stall_q = 1'b0;
            wrote   = 1'b0;
        end else begin
            if (bus.page_offset_buffer_wen) begin
                if (exp_buf.size() == 0) begin
                    chk("buf_write_unexpected", {bus.page_offset_buffer_addr,
                        bus.page_offset_buffer_din}, 0);
                end else begin
                    chk("buf_write", {bus.page_offset_buffer_addr, bus.page_offset_buffer_din},
                        exp_buf.pop_front());
                end
                wrote     = 1'b1;
                wrote_tag = bus.page_offset_buffer_addr;
            end else begin
                chk("buf_din_idle_zero", bus.page_offset_buffer_din, 0);
            end
            if (bus.mtt_get_req_valid) begin
                if (stall_q) begin
                    chk("get_head_stable", bus.mtt_get_req_head, prev_head);
                end else if (bus.mtt_get_req_head[137:136] == 2'd1) begin
                    chk("buf_write_before_get", {wrote, wrote_tag},
                        {1'b1, bus.mtt_get_req_head[135:128]});
                    wrote = 1'b0;
                end
                if (bus.mtt_get_req_ready) begin
                    if (exp_get.size() == 0) begin
                        chk("get_unexpected", bus.mtt_get_req_head, 0);
                    end else begin
                        chk("get_head", bus.mtt_get_req_head, exp_get.pop_front());
                    end
                    stall_q = 1'b0;
                end else begin
                    stall_q   = 1'b1;
                    prev_head = bus.mtt_get_req_head;
                end
            end
            if (bus.mr_err_valid) begin
                if (exp_err.size() == 0) begin
                    chk("err_unexpected", bus.mr_err_tag, 0);
                end else begin
                    chk("err_tag", bus.mr_err_tag, exp_err.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        //        tag    vaddr                 sva                   len       base
        //        err  cnt  off     icm0     icm1     lat
        vec[0] = '{8'h03, 64'h1000_0100, 64'h1000_0000, 32'h80, 64'h4000,
                   1'b0, 2'd1, 12'h100, 64'h4000, 64'h0, 4};
        vec[1] = '{8'h07, 64'h1000_2F00, 64'h1000_0000, 32'h200, 64'h4000,
                   1'b0, 2'd2, 12'hF00, 64'h4010, 64'h4018, 5};
        vec[2] = '{8'h05, 64'h1000_0F00, 64'h1000_0000, 32'h1200, 64'h4000,
                   1'b1, 2'd0, 12'h000, 64'h0, 64'h0, 3};
        vec[3] = '{8'h09, 64'h1000_0F00, 64'h1000_0000, 32'h100, 64'h4000,
                   1'b0, 2'd1, 12'hF00, 64'h4000, 64'h0, 4};
        vec[4] = '{8'h0A, 64'h2000_0000, 64'h2000_0000, 32'h0, 64'h8000,
                   1'b0, 2'd1, 12'h000, 64'h8000, 64'h0, 4};
        vec[5] = '{8'h0B, 64'h0FFF_F000, 64'h1000_0000, 32'h10, 64'h4000,
                   1'b1, 2'd0, 12'h000, 64'h0, 64'h0, 3};
        vec[6] = '{8'h0C, 64'h1000_3000, 64'h1000_0000, 32'h2000, 64'h4000,
                   1'b0, 2'd2, 12'h000, 64'h4018, 64'h4020, 5};
        vec[7] = '{8'h0D, 64'h1000_1800, 64'h1000_0000, 32'h900, 64'h4000,
                   1'b0, 2'd2, 12'h800, 64'h4008, 64'h4010, 0};
        vec[8] = '{8'h0E, 64'h1000_2F00, 64'h1000_0000, 32'h200, 64'h4000,
                   1'b0, 2'd2, 12'hF00, 64'h4010, 64'h4018, 0};
        vec[9] = '{8'h0F, 64'h1000_0100, 64'h1000_0000, 32'h80, 64'h4000,
                   1'b0, 2'd1, 12'h100, 64'h4000, 64'h0, 4};

        rst                   = 1'b1;
        bus.mr_req_valid      = 1'b0;
        bus.mr_req_tag        = '0;
        bus.mr_req_vaddr      = '0;
        bus.mr_req_len        = '0;
        bus.mr_req_start_va   = '0;
        bus.mr_req_mtt_base   = '0;
        bus.mtt_get_req_ready = 1'b1;

        #12;
        chk_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed vectors with a zero-wait MTTCache.
        for (int i = 0; i < 7; i++) send(vec[i], 1'b1);

        // Stall in REQ_1 for five cycles.
        bus.mtt_get_req_ready = 1'b0;
        send(vec[7], 1'b0);
        wait_get_valid("stall_req0");
        bus.mtt_get_req_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.mtt_get_req_ready = 1'b0;
        chk("stall_req1_index", bus.mtt_get_req_head[137:136], 2);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        chk("stall_valid_held", bus.mtt_get_req_valid, 1);
        bus.mtt_get_req_ready = 1'b1;
        wait_idle("stall", n);

        // Asynchronous reset while stalled in REQ_0.
        bus.mtt_get_req_ready = 1'b0;
        send(vec[8], 1'b0);
        wait_get_valid("rst_req0");
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("mid_reset");
        exp_get.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.mtt_get_req_ready = 1'b1;
        send(vec[9], 1'b1);

        repeat (10) @(posedge clk);
        #1;
        chk("exp_get_drained", exp_get.size(), 0);
        chk("exp_buf_drained", exp_buf.size(), 0);
        chk("exp_err_drained", exp_err.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hwacc_mr_mtt_req_gen.md
Name: hwacc_mr_mtt_req_gen

Overview:
- Request side of the hardware-accelerated MR translation path; the response-side collector consumes its output.
- Accepts one MR translation request: tag, virtual address, length, MR start VA and MTT ICM base.
- Computes page offset and page count (1 or 2), stores {length, offset} in the PageOffsetBuffer at the request tag, then issues one MTT get per page to MTTCache.
- Out-of-range requests are rejected on an error channel.

Parameters:
ICM_ADDR_WIDTH, 64, ICM virtual address width of MTT entries
PHYSICAL_ADDR_WIDTH, 64, width of the reserved physical-address field in the MTT request head
COUNT_MAX, 2, maximum MTT entries per request
COUNT_MAX_LOG, 2, width of the count_total and count_index fields
MTT_ENTRY_SIZE_LOG, 3, log2 of the MTT entry size in bytes (8 B)
PAGE_SIZE_LOG, 12, log2 of the page size (4 KB)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
mr_req_valid  in  1  request valid
mr_req_tag  in  `MAX_REQ_TAG_NUM_LOG  request tag
mr_req_vaddr  in  64  access virtual address
mr_req_len  in  32  access length in bytes
mr_req_start_va  in  64  MR start virtual address
mr_req_mtt_base  in  ICM_ADDR_WIDTH  ICM address of the MR's first MTT entry
mr_req_ready  out  1  request ready
page_offset_buffer_wen  out  1  buffer write enable
page_offset_buffer_addr  out  `MAX_REQ_TAG_NUM_LOG  buffer address (the tag)
page_offset_buffer_din  out  44  {len[31:0], offset[11:0]}
mtt_get_req_valid  out  1  MTT get request valid
mtt_get_req_head  out  COUNT_MAX_LOG*2+`MAX_REQ_TAG_NUM_LOG+PHYSICAL_ADDR_WIDTH+ICM_ADDR_WIDTH  {count_total, count_index, tag, phys(0), icm_addr}
mtt_get_req_ready  in  1  MTTCache ready
mr_err_valid  out  1  rejected-request pulse
mr_err_tag  out  `MAX_REQ_TAG_NUM_LOG  tag of the rejected request

Behaviour:
- Reset (async, rst=1): state IDLE; mr_req_ready=0 while rst is asserted; all other outputs and registers 0. Reset mid-operation drops any partial request; no further buffer writes or MTT gets are issued for it.
- States: IDLE, CHECK, WR_BUF, REQ_0, REQ_1, ERR.
- IDLE: mr_req_ready=1. On valid&ready, register all inputs → CHECK. No other state asserts ready.
- CHECK (1 cycle):
  - offset = vaddr[11:0].
  - span = offset + len, computed in 33 bits.
  - count_total = 2 if span > 4096, else 1 (len=0 gives 1).
  - index = vaddr[63:12] - start_va[63:12].
  - icm_addr0 = mtt_base + (index << 3); icm_addr1 = icm_addr0 + 8; both modulo 2^ICM_ADDR_WIDTH.
  - If span > 8192 or vaddr < start_va → ERR, else → WR_BUF.
- WR_BUF (1 cycle): wen=1, addr=tag, din={len, offset} → REQ_0. addr=tag and din=0 in every other state; wen=0 outside WR_BUF.
- REQ_0: valid=1, head={count_total, 2'd1, tag, 64'd0, icm_addr0}. Head is stable while valid && !ready. On handshake: → REQ_1 if count_total==2, else → IDLE.
- REQ_1: valid=1, head={2'd2, 2'd2, tag, 64'd0, icm_addr1}. On handshake → IDLE.
- ERR (1 cycle): mr_err_valid=1, mr_err_tag=tag → IDLE. No buffer write, no MTT get.
- Timing: the PageOffsetBuffer write always precedes the first MTT get by at least one cycle, so the responder reads valid offset data.
- Minimum latency from accept to first mtt_get_req_valid is 3 cycles. Back-to-back throughput: 4 cycles per request for 1 page, 5 for 2 pages (0-wait MTTCache).
- mtt_get_req_ready held low keeps the block in REQ_x with valid and head unchanged. mr_req_valid is ignored outside IDLE.

Test Plan:
- vaddr=0x1000_0100, start_va=0x1000_0000, len=0x80, base=0x4000, tag=3 → din={0x80,0x100} at addr 3; one get: count_total=1, count_index=1, icm=0x4000; ready returns 1 four cycles after accept.
- vaddr=0x1000_2F00, start_va=0x1000_0000, len=0x200, base=0x4000, tag=7 → din={0x200,0xF00}; gets icm=0x4010 (count 2, index 1), then 0x4018 (count 2, index 2).
- offset=0xF00, len=0x1200 (span 0x2100 > 8192) → mr_err_valid pulses for 1 cycle with tag; wen stays 0; no get issued.
- mtt_get_req_ready low for 5 cycles in REQ_1 → valid held high, head constant; exactly one handshake counted.
- rst asserted in REQ_0 with ready low → all outputs 0 immediately; after release, a new request yields a single correct get with no stale second get.
- Boundary: offset=0xF00, len=0x100 (span=4096) → count_total=1; vaddr=start_va with len=0 → count_total=1, icm=base.
